// File: rtl/onehot_step_decoder.sv
// ============================================================================
//  Module      : onehot_step_decoder
//  Description : Registered binary-to-one-hot decoder. In step mode, the same
//                one-hot register runs as a ring counter T0..T(LAST_STEP)
//                with a wrap pulse on the return to step 0.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module onehot_step_decoder #(
  parameter  int SEL_W     = 4,
  parameter  int LAST_STEP = (1 << SEL_W) - 1,
  localparam int OUT_W     = 1 << SEL_W
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             mode_i,
  input  logic             in_valid_i,
  input  logic [SEL_W-1:0] in_sel_i,
  input  logic             step_en_i,
  input  logic             step_clr_i,
  output logic [OUT_W-1:0] out_o,
  output logic [SEL_W-1:0] index_o,
  output logic             out_valid_o,
  output logic             wrap_o
);

  // Final ring position expressed at the width of the index register.
  localparam logic [SEL_W-1:0] C_LAST_IDX = LAST_STEP[SEL_W-1:0];
  localparam logic [OUT_W-1:0] C_ONEHOT_0 = {{(OUT_W-1){1'b0}}, 1'b1};

  // The one-hot vector and the binary index are both kept as registers so
  // that neither output has a decoder or encoder behind its flop.
  logic [OUT_W-1:0] out_q,       out_d;
  logic [SEL_W-1:0] index_q,     index_d;
  logic             out_valid_q, out_valid_d;
  logic             wrap_q,      wrap_d;

  // Decoded form of in_sel, one comparator per output line.
  logic [OUT_W-1:0] w_dec;

  genvar g;
  generate
    for (g = 0; g < OUT_W; g++) begin : g_dec
      assign w_dec[g] = (in_sel_i == SEL_W'(g));
    end
  endgenerate

  // Step mode at the end of the ring, or sitting on an index above it that
  // decode mode left behind, both restart at step 0 and flag a wrap.
  logic w_at_end;
  assign w_at_end = (index_q >= C_LAST_IDX);

  // Next-state selection: mode picks decode or step behaviour each cycle;
  // in step mode a clear outranks an advance.
  always_comb begin
    out_d       = out_q;
    index_d     = index_q;
    out_valid_d = 1'b0;
    wrap_d      = 1'b0;
    if (mode_i) begin
      if (step_clr_i) begin
        out_d       = C_ONEHOT_0;
        index_d     = '0;
        out_valid_d = 1'b1;
      end else if (step_en_i) begin
        out_valid_d = 1'b1;
        if (w_at_end) begin
          out_d   = C_ONEHOT_0;
          index_d = '0;
          wrap_d  = 1'b1;
        end else begin
          out_d   = out_q << 1;
          index_d = index_q + 1'b1;
        end
      end
    end else if (in_valid_i) begin
      out_d       = w_dec;
      index_d     = in_sel_i;
      out_valid_d = 1'b1;
    end
  end

  // State register; reset parks the output on line 0 with both pulses low.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      out_q       <= C_ONEHOT_0;
      index_q     <= '0;
      out_valid_q <= 1'b0;
      wrap_q      <= 1'b0;
    end else begin
      out_q       <= out_d;
      index_q     <= index_d;
      out_valid_q <= out_valid_d;
      wrap_q      <= wrap_d;
    end
  end

  assign out_o       = out_q;
  assign index_o     = index_q;
  assign out_valid_o = out_valid_q;
  assign wrap_o      = wrap_q;

endmodule

`default_nettype wire

// File: tb/tb_onehot_step_decoder.sv
// ============================================================================
//  Module      : tb_onehot_step_decoder
//  Description : Directed self-checking bench. A main instance (SEL_W=4,
//                LAST_STEP=5) is tracked every cycle by an index-level model;
//                three small instances cover the parameter corners.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_onehot_step_decoder;

  localparam int LAST_A = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance stimulus and outputs.
  logic        reset, mode, in_valid, step_en, step_clr;
  logic [3:0]  in_sel;
  logic [15:0] out_a;
  logic [3:0]  idx_a;
  logic        ov_a, wr_a;

  // Corner instances share one stimulus set.
  logic        reset_x, mode_x, iv_x, en_x, clr_x;
  logic [5:0]  sel_x;
  logic [1:0]  out_b;  logic [0:0] idx_b; logic ov_b, wr_b;
  logic [63:0] out_c;  logic [5:0] idx_c; logic ov_c, wr_c;
  logic [3:0]  out_d;  logic [1:0] idx_d; logic ov_d, wr_d;

  int n_cmp  = 0;
  int n_fail = 0;

  onehot_step_decoder #(.SEL_W(4), .LAST_STEP(LAST_A)) u_dut (
    .clk_i(clk), .reset_i(reset), .mode_i(mode), .in_valid_i(in_valid),
    .in_sel_i(in_sel), .step_en_i(step_en), .step_clr_i(step_clr),
    .out_o(out_a), .index_o(idx_a), .out_valid_o(ov_a), .wrap_o(wr_a));

  onehot_step_decoder #(.SEL_W(1), .LAST_STEP(1)) u_dut_b (
    .clk_i(clk), .reset_i(reset_x), .mode_i(mode_x), .in_valid_i(iv_x),
    .in_sel_i(sel_x[0:0]), .step_en_i(en_x), .step_clr_i(clr_x),
    .out_o(out_b), .index_o(idx_b), .out_valid_o(ov_b), .wrap_o(wr_b));

  onehot_step_decoder #(.SEL_W(6)) u_dut_c (
    .clk_i(clk), .reset_i(reset_x), .mode_i(mode_x), .in_valid_i(iv_x),
    .in_sel_i(sel_x), .step_en_i(en_x), .step_clr_i(clr_x),
    .out_o(out_c), .index_o(idx_c), .out_valid_o(ov_c), .wrap_o(wr_c));

  onehot_step_decoder #(.SEL_W(2), .LAST_STEP(0)) u_dut_d (
    .clk_i(clk), .reset_i(reset_x), .mode_i(mode_x), .in_valid_i(iv_x),
    .in_sel_i(sel_x[1:0]), .step_en_i(en_x), .step_clr_i(clr_x),
    .out_o(out_d), .index_o(idx_d), .out_valid_o(ov_d), .wrap_o(wr_d));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Model of the main instance: tracks only the step number and the two
  // pulses; the one-hot vector is always derived as 1 << index.
  int          m_idx;
  bit          m_ov, m_wr;
  bit          m_known = 1'b0;
  logic [15:0] m_out;

  // Advance the model on each rising edge, then compare just after it.
  always @(posedge clk) begin
    if (reset) begin
      m_idx = 0; m_ov = 1'b0; m_wr = 1'b0; m_known = 1'b1;
    end else begin
      m_ov = 1'b0; m_wr = 1'b0;
      if (mode) begin
        if (step_clr) begin
          m_idx = 0; m_ov = 1'b1;
        end else if (step_en) begin
          m_ov = 1'b1;
          if (m_idx < LAST_A) m_idx = m_idx + 1;
          else begin m_idx = 0; m_wr = 1'b1; end
        end
      end else if (in_valid) begin
        m_idx = int'(in_sel); m_ov = 1'b1;
      end
    end
    #1;
    if (m_known) begin
      m_out = 16'(1) << m_idx;
      chk("model.out",       64'(out_a), 64'(m_out));
      chk("model.index",     64'(idx_a), 64'(m_idx));
      chk("model.out_valid", 64'(ov_a),  64'(m_ov));
      chk("model.wrap",      64'(wr_a),  64'(m_wr));
    end
  end

  // One cycle of main-instance stimulus; returns at the following falling edge.
  task automatic drv(input logic m, input logic v, input logic [3:0] s,
                     input logic e, input logic c);
    reset = 1'b0; mode = m; in_valid = v; in_sel = s; step_en = e; step_clr = c;
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  int exp_i [7] = '{1, 2, 3, 4, 5, 0, 1};
  int exp_w [7] = '{0, 0, 0, 0, 0, 1, 0};
  logic [15:0] e16;

  initial begin
    reset = 1'b1; mode = 1'b0; in_valid = 1'b0; in_sel = '0; step_en = 1'b0; step_clr = 1'b0;
    reset_x = 1'b1; mode_x = 1'b0; iv_x = 1'b0; sel_x = '0; en_x = 1'b0; clr_x = 1'b0;

    // Reset held two cycles with random inputs.
    repeat (2) begin
      mode = 1'($urandom); in_valid = 1'($urandom); in_sel = 4'($urandom);
      step_en = 1'($urandom); step_clr = 1'($urandom);
      @(negedge clk);
    end
    chk("reset.out",       64'(out_a), 64'h0001);
    chk("reset.index",     64'(idx_a), 64'd0);
    chk("reset.out_valid", 64'(ov_a),  64'd0);
    chk("reset.wrap",      64'(wr_a),  64'd0);

    // Decode sweep over every select value.
    for (int i = 0; i < 16; i++) begin
      drv(1'b0, 1'b1, 4'(i), 1'b0, 1'b0);
      if (i == 0) chk("decode.sel0.out", 64'(out_a), 64'h0001);
    end
    chk("decode.sel15.out",   64'(out_a), 64'h8000);
    chk("decode.sel15.index", 64'(idx_a), 64'd15);
    chk("decode.sel15.valid", 64'(ov_a),  64'd1);
    drv(1'b0, 1'b0, 4'd3, 1'b0, 1'b0);
    chk("decode.hold.out",    64'(out_a), 64'h8000);
    chk("decode.hold.valid",  64'(ov_a),  64'd0);

    // Step ring with LAST_STEP=5, starting from a clear.
    drv(1'b1, 1'b0, 4'd0, 1'b0, 1'b1);
    chk("step.clr.index", 64'(idx_a), 64'd0);
    chk("step.clr.valid", 64'(ov_a),  64'd1);
    for (int k = 0; k < 7; k++) begin
      drv(1'b1, 1'b0, 4'd0, 1'b1, 1'b0);
      e16 = 16'(1) << exp_i[k];
      chk("step.ring.index", 64'(idx_a), 64'(exp_i[k]));
      chk("step.ring.wrap",  64'(wr_a),  64'(exp_w[k]));
      chk("step.ring.out",   64'(out_a), 64'(e16));
    end

    // Priority: clear beats step_en at index 3; reset beats step_en.
    drv(1'b1, 1'b0, 4'd0, 1'b1, 1'b0);
    drv(1'b1, 1'b0, 4'd0, 1'b1, 1'b0);
    chk("prio.pre.index", 64'(idx_a), 64'd3);
    drv(1'b1, 1'b0, 4'd0, 1'b1, 1'b1);
    chk("prio.clr.index", 64'(idx_a), 64'd0);
    chk("prio.clr.wrap",  64'(wr_a),  64'd0);
    drv(1'b1, 1'b0, 4'd0, 1'b1, 1'b0);
    drv(1'b1, 1'b0, 4'd0, 1'b1, 1'b0);
    reset = 1'b1; mode = 1'b1; step_en = 1'b1; step_clr = 1'b0;
    @(negedge clk);
    chk("prio.reset.index", 64'(idx_a), 64'd0);
    chk("prio.reset.valid", 64'(ov_a),  64'd0);
    chk("prio.reset.wrap",  64'(wr_a),  64'd0);

    // Mode handoff: an out-of-range decoded index wraps on the first step.
    drv(1'b0, 1'b1, 4'd9, 1'b0, 1'b0);
    chk("handoff.load.out",  64'(out_a), 64'h0200);
    drv(1'b1, 1'b0, 4'd0, 1'b1, 1'b0);
    chk("handoff.step.index", 64'(idx_a), 64'd0);
    chk("handoff.step.out",   64'(out_a), 64'h0001);
    chk("handoff.step.wrap",  64'(wr_a),  64'd1);
    drv(1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    chk("handoff.back.index", 64'(idx_a), 64'd0);
    chk("handoff.back.valid", 64'(ov_a),  64'd0);

    // Each mode ignores the other's controls.
    drv(1'b0, 1'b1, 4'd12, 1'b0, 1'b0);
    drv(1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
    chk("ignore.decode.index", 64'(idx_a), 64'd12);
    drv(1'b1, 1'b1, 4'd7, 1'b0, 1'b0);
    chk("ignore.step.index",   64'(idx_a), 64'd12);
    chk("ignore.step.valid",   64'(ov_a),  64'd0);
    drv(1'b1, 1'b1, 4'd7, 1'b1, 1'b0);
    chk("ignore.step.wrapidx", 64'(idx_a), 64'd0);
    chk("ignore.step.wrap",    64'(wr_a),  64'd1);
    drv(1'b0, 1'b0, 4'd0, 1'b0, 1'b0);

    // Parameter corners: SEL_W=1/LAST=1, SEL_W=6, LAST_STEP=0.
    reset_x = 1'b0; mode_x = 1'b1; en_x = 1'b1;
    @(negedge clk);
    chk("corner.b.step1.out",  64'(out_b), 64'h2);
    chk("corner.b.step1.wrap", 64'(wr_b),  64'd0);
    chk("corner.d.step1.out",  64'(out_d), 64'h1);
    chk("corner.d.step1.wrap", 64'(wr_d),  64'd1);
    @(negedge clk);
    chk("corner.b.step2.out",  64'(out_b), 64'h1);
    chk("corner.b.step2.wrap", 64'(wr_b),  64'd1);
    chk("corner.d.step2.idx",  64'(idx_d), 64'd0);
    @(negedge clk);
    chk("corner.b.step3.out",  64'(out_b), 64'h2);
    mode_x = 1'b0; en_x = 1'b0; iv_x = 1'b1; sel_x = 6'd63;
    @(negedge clk);
    chk("corner.c.sel63.out",   out_c,      64'h8000_0000_0000_0000);
    chk("corner.c.sel63.index", 64'(idx_c), 64'd63);
    chk("corner.d.sel3.out",    64'(out_d), 64'h8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
